// File: rtl/komut_bellegi_pkg.sv
// Shared types and constants for the instruction memory responder.
package komut_bellegi_pkg;

  // Loader/run state of the instruction memory.
  typedef enum logic [1:0] {
    BEKLE    = 2'd0,
    YUKLE    = 2'd1,
    CALISTIR = 2'd2
  } bellek_durum_t;

  // RISC-V "addi x0, x0, 0": harmless filler for blocked or invalid fetches.
  localparam logic [31:0] NOP_KOMUT = 32'h0000_0013;

endpackage

// File: rtl/bayt_birlestirici.sv
// Byte-serial word assembler: collects little-endian bytes into a 32-bit
// word and issues a write strobe on the 4th byte or on a flush request.
// Lanes not yet filled are kept at zero, so a flushed partial word is
// zero-extended without extra masking.
module bayt_birlestirici
  import komut_bellegi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        temizle_i,   // drop any partial word (load (re)start)
  input  logic        bayt_al_i,   // bayt_i is accepted this cycle
  input  logic [7:0]  bayt_i,
  input  logic        bosalt_i,    // end of load: write out a partial word
  output logic [31:0] kelime,
  output logic        kelime_yaz
);

  logic [1:0]  bayt_idx_q, bayt_idx_d;
  logic [31:0] serit_q, serit_d;
  logic [31:0] birlesik_s;

  // Merge the byte accepted this cycle into its lane so the full word can
  // be written on the same edge that accepts the last byte.
  always_comb begin
    birlesik_s = serit_q;
    if (bayt_al_i) begin
      case (bayt_idx_q)
        2'd0:    birlesik_s[7:0]   = bayt_i;
        2'd1:    birlesik_s[15:8]  = bayt_i;
        2'd2:    birlesik_s[23:16] = bayt_i;
        2'd3:    birlesik_s[31:24] = bayt_i;
        default: birlesik_s        = serit_q;
      endcase
    end else begin
      birlesik_s = serit_q;
    end
  end

  // A byte accepted together with the flush is stored first; the flush then
  // only writes if something is actually held.
  assign kelime     = birlesik_s;
  assign kelime_yaz = (bayt_al_i && (bayt_idx_q == 2'd3)) ||
                      (bosalt_i && (bayt_al_i || (bayt_idx_q != 2'd0)));

  // Next lane index and lane contents.
  always_comb begin
    bayt_idx_d = bayt_idx_q;
    serit_d    = serit_q;
    if (temizle_i) begin
      bayt_idx_d = 2'd0;
      serit_d    = 32'd0;
    end else if (kelime_yaz) begin
      bayt_idx_d = 2'd0;
      serit_d    = 32'd0;
    end else if (bayt_al_i) begin
      bayt_idx_d = bayt_idx_q + 2'd1;
      serit_d    = birlesik_s;
    end else begin
      bayt_idx_d = bayt_idx_q;
      serit_d    = serit_q;
    end
  end

  // Lane index and lane registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bayt_idx_q <= 2'd0;
      serit_q    <= 32'd0;
    end else begin
      bayt_idx_q <= bayt_idx_d;
      serit_q    <= serit_d;
    end
  end

endmodule

// File: rtl/komut_bellegi.sv
// Instruction memory for the single-cycle processor: byte-serial program
// loader, processor reset hold-off until loaded, and a combinational fetch
// port that flags misaligned or out-of-program addresses.
module komut_bellegi
  import komut_bellegi_pkg::*;
#(
  parameter int          DERINLIK  = 256,
  parameter logic [31:0] NOP_KOMUT = komut_bellegi_pkg::NOP_KOMUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  pc_bellek,
  output logic [31:0]                  komut_bellek,
  output logic                         hata_bellek,
  input  logic                         yukle_basla,
  input  logic [7:0]                   yukle_byte,
  input  logic                         yukle_gecerli,
  output logic                         yukle_hazir,
  input  logic                         yukle_bitti,
  output logic                         islemci_reset,
  output logic [$clog2(DERINLIK):0]    kelime_sayisi
);

  localparam int              AW         = $clog2(DERINLIK);
  localparam logic [AW:0]     DERINLIK_K = (AW+1)'(DERINLIK);
  localparam logic [AW:0]     BIR_K      = (AW+1)'(1);
  // Address bits above the word-index field must all be zero.
  localparam logic [31:0]     UST_MASKE  = ~((32'd1 << (AW + 2)) - 32'd1);

  bellek_durum_t durum_q, durum_d;
  logic [AW:0]   sayi_q, sayi_d;
  logic          islemci_reset_q;
  logic          yukle_hazir_q;

  logic          bayt_al_s;
  logic          bosalt_s;
  logic [31:0]   kelime_s;
  logic          kelime_yaz_s;

  logic [31:0]   bellek_q [DERINLIK];

  logic [AW-1:0] idx_s;
  logic          ust_s;

  // yukle_basla outranks both the flush and byte acceptance.
  assign bayt_al_s = (durum_q == YUKLE) && yukle_gecerli && yukle_hazir_q && !yukle_basla;
  assign bosalt_s  = (durum_q == YUKLE) && yukle_bitti && !yukle_basla;

  bayt_birlestirici u_birlestirici (
    .clk        (clk),
    .reset      (reset),
    .temizle_i  (yukle_basla),
    .bayt_al_i  (bayt_al_s),
    .bayt_i     (yukle_byte),
    .bosalt_i   (bosalt_s),
    .kelime     (kelime_s),
    .kelime_yaz (kelime_yaz_s)
  );

  // Next state and word count.
  always_comb begin
    durum_d = durum_q;
    sayi_d  = sayi_q;
    if (yukle_basla) begin
      durum_d = YUKLE;
      sayi_d  = '0;
    end else begin
      case (durum_q)
        BEKLE:    durum_d = BEKLE;
        YUKLE:    durum_d = yukle_bitti ? CALISTIR : YUKLE;
        CALISTIR: durum_d = CALISTIR;
        default:  durum_d = BEKLE;
      endcase
      if (kelime_yaz_s) begin
        sayi_d = sayi_q + BIR_K;
      end else begin
        sayi_d = sayi_q;
      end
    end
  end

  // State, count and registered Moore outputs (decoded from next state so
  // they line up with the state they describe).
  always_ff @(posedge clk) begin
    if (reset) begin
      durum_q         <= BEKLE;
      sayi_q          <= '0;
      islemci_reset_q <= 1'b1;
      yukle_hazir_q   <= 1'b0;
    end else begin
      durum_q         <= durum_d;
      sayi_q          <= sayi_d;
      islemci_reset_q <= (durum_d != CALISTIR);
      yukle_hazir_q   <= (durum_d == YUKLE) && (sayi_d < DERINLIK_K);
    end
  end

  // Program store; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (kelime_yaz_s && !reset) begin
      bellek_q[sayi_q[AW-1:0]] <= kelime_s;
    end
  end

  assign idx_s = pc_bellek[AW+1:2];
  assign ust_s = |(pc_bellek & UST_MASKE);

  // Combinational fetch: the single-cycle processor needs the word in the
  // same cycle it presents pc.
  always_comb begin
    komut_bellek = NOP_KOMUT;
    hata_bellek  = 1'b0;
    if (durum_q == CALISTIR) begin
      if ((pc_bellek[1:0] != 2'b00) || ({1'b0, idx_s} >= sayi_q) || ust_s) begin
        hata_bellek  = 1'b1;
        komut_bellek = NOP_KOMUT;
      end else begin
        hata_bellek  = 1'b0;
        komut_bellek = bellek_q[idx_s];
      end
    end else begin
      hata_bellek  = 1'b0;
      komut_bellek = NOP_KOMUT;
    end
  end

  assign islemci_reset = islemci_reset_q;
  assign yukle_hazir   = yukle_hazir_q;
  assign kelime_sayisi = sayi_q;

endmodule

// File: tb/tb_komut_bellegi.sv
// Directed bench for komut_bellegi: fetch table plus load/reset sequences.
module tb_komut_bellegi;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_bellek = 32'd0;
  logic [31:0] komut_bellek;
  logic        hata_bellek;
  logic        yukle_basla = 1'b0;
  logic [7:0]  yukle_byte = 8'd0;
  logic        yukle_gecerli = 1'b0;
  logic        yukle_hazir;
  logic        yukle_bitti = 1'b0;
  logic        islemci_reset;
  logic [8:0]  kelime_sayisi;

  int n_run  = 0;
  int n_fail = 0;

  komut_bellegi #(.DERINLIK(256), .NOP_KOMUT(32'h0000_0013)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_bellek     (pc_bellek),
    .komut_bellek  (komut_bellek),
    .hata_bellek   (hata_bellek),
    .yukle_basla   (yukle_basla),
    .yukle_byte    (yukle_byte),
    .yukle_gecerli (yukle_gecerli),
    .yukle_hazir   (yukle_hazir),
    .yukle_bitti   (yukle_bitti),
    .islemci_reset (islemci_reset),
    .kelime_sayisi (kelime_sayisi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] komut;
    logic        hata;
  } vek_t;

  vek_t tablo [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bayt(input logic [7:0] b);
    yukle_gecerli = 1'b1;
    yukle_byte    = b;
    step();
    yukle_gecerli = 1'b0;
  endtask

  task automatic basla();
    yukle_basla = 1'b1;
    step();
    yukle_basla = 1'b0;
  endtask

  task automatic bitti();
    yukle_bitti = 1'b1;
    step();
    yukle_bitti = 1'b0;
  endtask

  task automatic fetch(input string nm, input logic [31:0] pc, input logic [31:0] k, input logic h);
    pc_bellek = pc;
    #1;
    chk({nm, "_komut"}, komut_bellek, k);
    chk({nm, "_hata"}, {31'd0, hata_bellek}, {31'd0, h});
  endtask

  initial begin
    tablo[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
    tablo[1] = '{32'h0000_0004, 32'h0010_0513, 1'b0};
    tablo[2] = '{32'h0000_0008, NOP,           1'b1};
    tablo[3] = '{32'h0000_0002, NOP,           1'b1};
    tablo[4] = '{32'h0000_0400, NOP,           1'b1};
    tablo[5] = '{32'h8000_0000, NOP,           1'b1};
    tablo[6] = '{32'h0000_03FC, NOP,           1'b1};
    tablo[7] = '{32'h0000_0001, NOP,           1'b1};

    // Reset state
    step(); step();
    reset = 1'b0;
    fetch("rst", 32'd0, NOP, 1'b0);
    chk("rst_islemci_reset", {31'd0, islemci_reset}, 32'd1);
    chk("rst_hazir", {31'd0, yukle_hazir}, 32'd0);
    chk("rst_sayi", {23'd0, kelime_sayisi}, 32'd0);

    // Two-word load
    basla();
    chk("yukle_hazir", {31'd0, yukle_hazir}, 32'd1);
    fetch("yukle_fetch", 32'd0, NOP, 1'b0);
    bayt(8'h93); bayt(8'h00); bayt(8'h50); bayt(8'h00);
    bayt(8'h13); bayt(8'h05); bayt(8'h10); bayt(8'h00);
    chk("iki_sayi", {23'd0, kelime_sayisi}, 32'd2);
    chk("iki_islemci_reset_yukle", {31'd0, islemci_reset}, 32'd1);
    bitti();
    chk("iki_islemci_reset", {31'd0, islemci_reset}, 32'd0);
    chk("iki_hazir", {31'd0, yukle_hazir}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      fetch($sformatf("tablo%0d", i), tablo[i].pc, tablo[i].komut, tablo[i].hata);
    end

    // Byte and bitti in the same cycle
    basla();
    chk("restart_sayi", {23'd0, kelime_sayisi}, 32'd0);
    chk("restart_islemci_reset", {31'd0, islemci_reset}, 32'd1);
    bayt(8'h13);
    yukle_bitti = 1'b1;
    bayt(8'h05);
    yukle_bitti = 1'b0;
    chk("esz_sayi", {23'd0, kelime_sayisi}, 32'd1);
    chk("esz_islemci_reset", {31'd0, islemci_reset}, 32'd0);
    fetch("esz_w0", 32'd0, 32'h0000_0513, 1'b0);
    fetch("esz_w1", 32'd4, NOP, 1'b1);

    // Partial flush without a byte: zero-filled upper lane
    basla();
    bayt(8'h11); bayt(8'h22); bayt(8'h33);
    bitti();
    chk("kismi_sayi", {23'd0, kelime_sayisi}, 32'd1);
    fetch("kismi_w0", 32'd0, 32'h0033_2211, 1'b0);

    // Empty load: every fetch errors
    basla();
    bitti();
    chk("bos_islemci_reset", {31'd0, islemci_reset}, 32'd0);
    fetch("bos_w0", 32'd0, NOP, 1'b1);

    // Fill the memory completely
    basla();
    for (int i = 0; i < 1023; i++) begin
      bayt(8'(i));
    end
    chk("dolu_once_hazir", {31'd0, yukle_hazir}, 32'd1);
    chk("dolu_once_sayi", {23'd0, kelime_sayisi}, 32'd255);
    bayt(8'hFF);
    chk("dolu_sayi", {23'd0, kelime_sayisi}, 32'd256);
    chk("dolu_hazir", {31'd0, yukle_hazir}, 32'd0);
    bayt(8'hEE);
    chk("dolu_fazla_sayi", {23'd0, kelime_sayisi}, 32'd256);
    bitti();
    fetch("dolu_w0", 32'h0000_0000, 32'h0302_0100, 1'b0);
    fetch("dolu_w128", 32'h0000_0200, 32'h0302_0100, 1'b0);
    fetch("dolu_w255", 32'h0000_03FC, 32'hFFFE_FDFC, 1'b0);
    fetch("dolu_w1", 32'h0000_0004, 32'h0706_0504, 1'b0);
    fetch("dolu_ust", 32'h0000_0400, NOP, 1'b1);

    // Reset in the middle of a load
    basla();
    bayt(8'h01); bayt(8'h02); bayt(8'h03); bayt(8'h04); bayt(8'h05);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_sayi", {23'd0, kelime_sayisi}, 32'd0);
    chk("rst2_islemci_reset", {31'd0, islemci_reset}, 32'd1);
    chk("rst2_hazir", {31'd0, yukle_hazir}, 32'd0);
    fetch("rst2_fetch", 32'd0, NOP, 1'b0);
    basla();
    bayt(8'hAA); bayt(8'hBB); bayt(8'hCC); bayt(8'hDD);
    chk("rst2_yeni_sayi", {23'd0, kelime_sayisi}, 32'd1);
    bitti();
    fetch("rst2_w0", 32'd0, 32'hDDCC_BBAA, 1'b0);
    fetch("rst2_w1", 32'd4, NOP, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
